// File: rtl/mac_tile_simd.sv
// SIMD multiply-accumulate tile: lanes of unsigned activation slices times signed
// weights, shifted per precision mode and summed into a north-to-south partial sum.
module mac_tile_simd #(
   parameter int bw      = 2,
   parameter int b_bw    = 4,
   parameter int psum_bw = 32,
   parameter int lanes   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [lanes*bw-1:0]   in_w,
   output logic [lanes*bw-1:0]   out_e,
   input  logic [psum_bw-1:0]    in_n,
   output logic [psum_bw-1:0]    out_s,
   input  logic [3:0]            inst_w,
   output logic [3:0]            inst_e,
   output logic                  load_done
);

   localparam int CW = (lanes > 1) ? $clog2(lanes) : 1;
   localparam int PW = bw + b_bw + 1;

   typedef enum logic [1:0] {EMPTY, LOADING, LOADED} state_t;

   state_t                        r_state;
   logic [CW-1:0]                 r_cnt;
   logic [1:0]                    r_lmode;
   logic [lanes-1:0][b_bw-1:0]    r_w;
   logic [lanes*bw-1:0]           r_a;
   logic [psum_bw-1:0]            r_c;
   logic [psum_bw-1:0]            r_dot;
   logic [3:0]                    r_inst;
   logic                          r_done;

   logic                          w_beat_en;
   logic [1:0]                    w_lm;
   logic                          w_last;
   logic [lanes-1:0][b_bw-1:0]    w_w_nxt;
   logic [psum_bw-1:0]            w_sum;

   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'b11) ? 2'b00 : m;
   endfunction

   assign w_beat_en = inst_w[0] && (r_state != LOADED);
   assign w_lm      = norm_mode((r_state == EMPTY) ? inst_w[3:2] : r_lmode);

   always_comb begin
      w_last = 1'b0;
      case (w_lm)
         2'b01:   w_last = (r_cnt == CW'(lanes/2 - 1));
         2'b10:   w_last = 1'b1;
         default: w_last = (r_cnt == CW'(lanes - 1));
      endcase
   end

   always_comb begin
      w_w_nxt = r_w;
      if (w_beat_en) begin
         for (int i = 0; i < lanes; i++) begin
            case (w_lm)
               2'b01:   if (r_cnt == CW'(i/2)) w_w_nxt[i] = in_w[b_bw-1:0];
               2'b10:   w_w_nxt[i] = in_w[b_bw-1:0];
               default: if (r_cnt == CW'(i))   w_w_nxt[i] = in_w[b_bw-1:0];
            endcase
         end
      end
   end

   // The dot product is formed from the incoming slices and the weights held before
   // this edge, then registered; on an execute cycle in_w is exactly what a_q captures,
   // so this matches a_q x w while keeping a simultaneous load beat out of the result.
   always_comb begin
      logic signed [PW-1:0]      v_a;
      logic signed [PW-1:0]      v_w;
      logic signed [PW-1:0]      v_p;
      logic        [psum_bw-1:0] v_ext;
      int                        v_sh;
      w_sum = '0;
      for (int i = 0; i < lanes; i++) begin
         v_a   = {{(PW-bw){1'b0}}, in_w[i*bw +: bw]};
         v_w   = {{(PW-b_bw){r_w[i][b_bw-1]}}, r_w[i]};
         v_p   = v_a * v_w;
         v_ext = {{(psum_bw-PW){v_p[PW-1]}}, v_p};
         case (inst_w[3:2])
            2'b01:   v_sh = (i % 2) * bw;
            2'b10:   v_sh = i * bw;
            default: v_sh = 0;
         endcase
         w_sum = w_sum + (v_ext << v_sh);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
         r_cnt   <= '0;
         r_lmode <= 2'b00;
         r_w     <= '0;
         r_a     <= '0;
         r_c     <= '0;
         r_dot   <= '0;
         r_inst  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_c    <= in_n;
         r_dot  <= w_sum;
         r_w    <= w_w_nxt;
         r_inst <= {inst_w[3:1], (r_state == LOADED) & inst_w[0]};
         if (inst_w[1] | inst_w[0]) r_a <= in_w;
         if (w_beat_en) begin
            if (r_state == EMPTY) r_lmode <= norm_mode(inst_w[3:2]);
            if (w_last) begin
               r_state <= LOADED;
               r_done  <= 1'b1;
               r_cnt   <= '0;
            end else begin
               r_state <= LOADING;
               r_cnt   <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign out_e     = r_a;
   assign inst_e    = r_inst;
   assign load_done = r_done;
   assign out_s     = r_inst[1] ? (r_c + r_dot) : r_c;

endmodule
